// File: rtl/rf_pkg.sv
// Shared widths, types and helpers for the multi-port register file.
package rf_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    function automatic int addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int AW_DEF = addr_w(NREGS_DEF);

    typedef logic [XLEN_DEF-1:0] xlen_t;
    typedef logic [AW_DEF-1:0]   regaddr_t;

    localparam regaddr_t REG_ZERO = '0;
endpackage

// File: rtl/rf_wr_select.sv
// Priority select of writeback ports that target one address; the highest
// (youngest) matching port wins.
module rf_wr_select
    import rf_pkg::*;
#(
    parameter int NWR  = 2,
    parameter int AW   = AW_DEF,
    parameter int XLEN = XLEN_DEF
) (
    input  logic [NWR-1:0]           i_wr_en,
    input  logic [NWR-1:0][AW-1:0]   i_wr_addr,
    input  logic [NWR-1:0][XLEN-1:0] i_wr_data,
    input  logic [AW-1:0]            i_tgt,
    output logic                     o_hit,
    output logic [XLEN-1:0]          o_data
);
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        // Ascending scan: a later match overrides, so the youngest port wins.
        for (int p = 0; p < NWR; p++) begin
            if (i_wr_en[p] && (i_wr_addr[p] == i_tgt)) begin
                o_hit  = 1'b1;
                o_data = i_wr_data[p];
            end
        end
    end
endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port register file with same-cycle write bypass and a pending-write
// scoreboard for RAW hazard detection at issue.
module regfile_mp_scoreboard
    import rf_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 4,
    parameter int NWR    = 2,
    parameter bit BYPASS = 1'b1,
    localparam int AW    = addr_w(NREGS)
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [NRD-1:0][AW-1:0]   rd_addr,
    output logic [NRD-1:0][XLEN-1:0] rd_data,
    output logic [NRD-1:0]           rd_busy,
    input  logic [NWR-1:0]           wr_en,
    input  logic [NWR-1:0][AW-1:0]   wr_addr,
    input  logic [NWR-1:0][XLEN-1:0] wr_data,
    input  logic [NWR-1:0]           alloc_en,
    input  logic [NWR-1:0][AW-1:0]   alloc_addr,
    input  logic                     flush,
    output logic [NREGS-1:0]         busy_vec
);
    logic [NREGS-1:0][XLEN-1:0] r_mem;
    logic [NREGS-1:0]           r_busy;

    logic [NREGS-1:0]           w_cmt_hit;
    logic [NREGS-1:0][XLEN-1:0] w_cmt_data;
    logic [NRD-1:0]             w_byp_hit;
    logic [NRD-1:0][XLEN-1:0]   w_byp_data;
    logic [NREGS-1:0]           w_alloc_hit;

    for (genvar r = 0; r < NREGS; r++) begin : g_cmt
        rf_wr_select #(.NWR(NWR), .AW(AW), .XLEN(XLEN)) u_sel (
            .i_wr_en   (wr_en),
            .i_wr_addr (wr_addr),
            .i_wr_data (wr_data),
            .i_tgt     (AW'(r)),
            .o_hit     (w_cmt_hit[r]),
            .o_data    (w_cmt_data[r])
        );
    end

    for (genvar k = 0; k < NRD; k++) begin : g_byp
        rf_wr_select #(.NWR(NWR), .AW(AW), .XLEN(XLEN)) u_sel (
            .i_wr_en   (wr_en),
            .i_wr_addr (wr_addr),
            .i_wr_data (wr_data),
            .i_tgt     (rd_addr[k]),
            .o_hit     (w_byp_hit[k]),
            .o_data    (w_byp_data[k])
        );
    end

    always_comb begin
        w_alloc_hit = '0;
        for (int p = 0; p < NWR; p++)
            if (alloc_en[p]) w_alloc_hit[alloc_addr[p]] = 1'b1;
        w_alloc_hit[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_mem  <= '0;
            r_busy <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (r != 0) begin
                    if (w_cmt_hit[r]) r_mem[r] <= w_cmt_data[r];
                    // Flush beats a new allocation, which beats a retiring write.
                    if (flush)               r_busy[r] <= 1'b0;
                    else if (w_alloc_hit[r]) r_busy[r] <= 1'b1;
                    else if (w_cmt_hit[r])   r_busy[r] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        if (n_rst) begin
            for (int k = 0; k < NRD; k++) begin
                rd_data[k] = r_mem[rd_addr[k]];
                rd_busy[k] = r_busy[rd_addr[k]];
                if (BYPASS && w_byp_hit[k] && (rd_addr[k] != AW'(REG_ZERO))) begin
                    rd_data[k] = w_byp_data[k];
                    if (!w_alloc_hit[rd_addr[k]]) rd_busy[k] = 1'b0;
                end
            end
        end
    end

    assign busy_vec = r_busy;
endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed checks of the register file with bypass enabled and disabled side by side.
module tb_regfile_mp_scoreboard;
    localparam int XLEN = 32, NREGS = 32, NRD = 4, NWR = 2, AW = 5;

    logic clk = 1'b0;
    logic n_rst;
    logic [NRD-1:0][AW-1:0]   rd_addr;
    logic [NWR-1:0]           wr_en;
    logic [NWR-1:0][AW-1:0]   wr_addr;
    logic [NWR-1:0][XLEN-1:0] wr_data;
    logic [NWR-1:0]           alloc_en;
    logic [NWR-1:0][AW-1:0]   alloc_addr;
    logic                     flush;
    logic [NRD-1:0][XLEN-1:0] rd_d1, rd_d0;
    logic [NRD-1:0]           rd_b1, rd_b0;
    logic [NREGS-1:0]         bv1, bv0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_mp_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1'b1)) u_b1 (
        .clk(clk), .n_rst(n_rst), .rd_addr(rd_addr), .rd_data(rd_d1), .rd_busy(rd_b1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
        .alloc_addr(alloc_addr), .flush(flush), .busy_vec(bv1));

    regfile_mp_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1'b0)) u_b0 (
        .clk(clk), .n_rst(n_rst), .rd_addr(rd_addr), .rd_data(rd_d0), .rd_busy(rd_b0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
        .alloc_addr(alloc_addr), .flush(flush), .busy_vec(bv0));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = '0; alloc_en = '0; flush = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0; alloc_addr = '0; idle();
        #12;
        chk("rst_bv1", bv1, 0);
        chk("rst_rd1", rd_d1[0], 0);
        n_rst = 1'b1;
        step();

        // Reset mid-stream: x5 written, x9 allocated, then async reset
        wr_en = 2'b01; wr_addr[0] = 5; wr_data[0] = 32'hDEADBEEF;
        alloc_en = 2'b10; alloc_addr[1] = 9;
        step(); idle();
        rd_addr[0] = 5; rd_addr[1] = 9;
        #1;
        chk("x5_pre_rst", rd_d0[0], 32'hDEADBEEF);
        chk("x9_busy_pre_rst", bv0[9], 1);
        wr_en = 2'b01; wr_data[0] = 32'h12345678;
        #1 n_rst = 1'b0;
        #1;
        chk("rst_mid_rd1", rd_d1[0], 0);
        chk("rst_mid_rd0", rd_d0[0], 0);
        chk("rst_mid_bv", bv1, 0);
        chk("rst_mid_rdbusy", rd_b0[1], 0);
        step(); n_rst = 1'b1; idle();
        #1;
        chk("x5_after_rst", rd_d0[0], 0);
        chk("x5_after_rst_b1", rd_d1[0], 0);

        // Collision on x7: younger port 1 wins
        wr_en = 2'b11; wr_addr[0] = 7; wr_addr[1] = 7; wr_data[0] = 32'h11; wr_data[1] = 32'h22;
        rd_addr[1] = 7;
        #1;
        chk("coll_bypass", rd_d1[1], 32'h22);
        chk("coll_nobyp_old", rd_d0[1], 0);
        step(); idle();
        chk("coll_commit", rd_d0[1], 32'h22);
        wr_en = 2'b11; wr_addr[1] = 8;
        rd_addr[2] = 8;
        step(); idle();
        chk("par_x7", rd_d0[1], 32'h11);
        chk("par_x8", rd_d0[2], 32'h22);

        // Bypass of x3 while it is allocated
        alloc_en = 2'b01; alloc_addr[0] = 3;
        step(); idle();
        rd_addr[0] = 3;
        wr_en = 2'b01; wr_addr[0] = 3; wr_data[0] = 32'hA5;
        #1;
        chk("byp_data", rd_d1[0], 32'hA5);
        chk("byp_busy", rd_b1[0], 0);
        chk("nobyp_data", rd_d0[0], 0);
        chk("nobyp_busy", rd_b0[0], 1);
        step(); idle();
        chk("nobyp_next", rd_d0[0], 32'hA5);
        chk("x3_busy_clr", bv0[3], 0);

        // Scoreboard on x9
        rd_addr[3] = 9;
        alloc_en = 2'b01; alloc_addr[0] = 9;
        step(); idle();
        chk("sb_alloc", bv1[9], 1);
        wr_en = 2'b10; wr_addr[1] = 9; wr_data[1] = 32'h99;
        alloc_en = 2'b10; alloc_addr[1] = 9;
        #1;
        chk("sb_wb_alloc_rdbusy", rd_b1[3], 1);
        step(); idle();
        chk("sb_wb_alloc", bv1[9], 1);
        wr_en = 2'b01; wr_addr[0] = 9; wr_data[0] = 32'h98;
        #1;
        chk("sb_lone_wb_rdbusy", rd_b1[3], 0);
        chk("sb_lone_wb_old", rd_b0[3], 1);
        step(); idle();
        chk("sb_wb_clear", bv1[9], 0);
        chk("sb_wb_data", rd_d0[3], 32'h98);

        // Flush with a concurrent writeback
        alloc_en = 2'b11; alloc_addr[0] = 4; alloc_addr[1] = 6;
        step(); idle();
        chk("fl_pre", bv1, 32'h50);
        flush = 1'b1; wr_en = 2'b01; wr_addr[0] = 4; wr_data[0] = 32'h7;
        alloc_en = 2'b10; alloc_addr[1] = 10;
        rd_addr[0] = 4;
        step(); idle();
        chk("fl_bv", bv0, 0);
        chk("fl_x4", rd_d0[0], 32'h7);

        // Register 0 is hardwired
        rd_addr[0] = 0;
        alloc_en = 2'b11; alloc_addr[0] = 0; alloc_addr[1] = 0;
        wr_en = 2'b11; wr_addr[0] = 0; wr_addr[1] = 0; wr_data[0] = 32'hFFFF; wr_data[1] = 32'hFFFF;
        #1;
        chk("x0_byp", rd_d1[0], 0);
        chk("x0_rdbusy", rd_b1[0], 0);
        step(); idle();
        chk("x0_bv", bv1[0], 0);
        chk("x0_rd", rd_d0[0], 0);
        chk("x0_bv_all", bv1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
